// File: rtl/felix_link_pkg.sv
// FELIX full-mode TX link framing definitions.
// Shared by the half-word classifier and the link monitor.
package felix_link_pkg;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_SOP  = 8'h3C;
  localparam logic [7:0] K_EOP  = 8'hDC;

  localparam int ERR_SOP_IN_FRAME = 0;
  localparam int ERR_EOP_IDLE     = 1;
  localparam int ERR_DATA_IDLE    = 2;
  localparam int ERR_BADK         = 3;

  typedef enum logic [2:0] {
    H_IDLE,
    H_SOP,
    H_EOP,
    H_DATA,
    H_BADK
  } half_t;

  typedef enum logic {
    IDLE_ST,
    FRAME_ST
  } st_t;

  typedef struct packed {
    st_t         st;
    logic [15:0] len;
    logic [3:0]  err;
    logic        done;
    logic [15:0] done_len;
  } step_t;

  // One half-word of the framing state machine.
  function automatic step_t step(
    input st_t         st,
    input logic [15:0] len,
    input half_t       h
  );
    step_t s;
    s.st       = st;
    s.len      = len;
    s.err      = '0;
    s.done     = 1'b0;
    s.done_len = '0;
    if (st == IDLE_ST) begin
      unique case (h)
        H_SOP: begin
          s.st  = FRAME_ST;
          s.len = '0;
        end
        H_EOP:   s.err[ERR_EOP_IDLE]  = 1'b1;
        H_DATA:  s.err[ERR_DATA_IDLE] = 1'b1;
        H_BADK:  s.err[ERR_BADK]      = 1'b1;
        default: ;
      endcase
    end else begin
      unique case (h)
        H_DATA: begin
          if (len != 16'hFFFF) s.len = len + 16'd1;
        end
        H_EOP: begin
          s.done     = 1'b1;
          s.done_len = len;
          s.st       = IDLE_ST;
        end
        H_SOP: begin
          s.err[ERR_SOP_IN_FRAME] = 1'b1;
          s.len = '0;
        end
        H_BADK: begin
          s.err[ERR_BADK] = 1'b1;
          s.st = IDLE_ST;
        end
        default: ;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/felix_half_classify.sv
// Classifies one 32-bit half-word of the K stream.
// Purely combinational.
module felix_half_classify #(
  parameter logic [7:0] K_IDLE = felix_link_pkg::K_IDLE,
  parameter logic [7:0] K_SOP  = felix_link_pkg::K_SOP,
  parameter logic [7:0] K_EOP  = felix_link_pkg::K_EOP
) (
  input  logic [31:0]          data,
  input  logic [3:0]           k,
  output felix_link_pkg::half_t cls
);
  import felix_link_pkg::*;

  logic kc;
  assign kc = (k == 4'b0001);

  always_comb begin
    cls = H_BADK;
    unique case (1'b1)
      (k == 4'b0000):              cls = H_DATA;
      (kc && data[7:0] == K_IDLE): cls = H_IDLE;
      (kc && data[7:0] == K_SOP):  cls = H_SOP;
      (kc && data[7:0] == K_EOP):  cls = H_EOP;
      default:                     cls = H_BADK;
    endcase
  end

endmodule

// File: rtl/felix_tx_link_monitor.sv
// Passive framing monitor for the FELIX TX K stream.
// Passes the stream through with one cycle of latency.
module felix_tx_link_monitor #(
  parameter logic [7:0] K_IDLE = felix_link_pkg::K_IDLE,
  parameter logic [7:0] K_SOP  = felix_link_pkg::K_SOP,
  parameter logic [7:0] K_EOP  = felix_link_pkg::K_EOP
) (
  input  logic        clk120,
  input  logic        rst,
  input  logic [63:0] data_in,
  input  logic [7:0]  k_in,
  input  logic        clr_cnt,
  output logic [63:0] data_out,
  output logic [7:0]  k_out,
  output logic        in_frame,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] last_len,
  output logic [3:0]  err_flags,
  output logic        err_pulse
);
  import felix_link_pkg::*;

  half_t       cls_lo;
  half_t       cls_hi;
  st_t         st;
  logic [15:0] len;
  step_t       lo;
  step_t       hi;
  logic [1:0]  n_err;
  logic [16:0] err_sum;
  logic        done;
  logic [15:0] done_len;

  felix_half_classify #(
    .K_IDLE(K_IDLE), .K_SOP(K_SOP), .K_EOP(K_EOP)
  ) u_cls_lo (
    .data(data_in[31:0]),
    .k   (k_in[3:0]),
    .cls (cls_lo)
  );

  felix_half_classify #(
    .K_IDLE(K_IDLE), .K_SOP(K_SOP), .K_EOP(K_EOP)
  ) u_cls_hi (
    .data(data_in[63:32]),
    .k   (k_in[7:4]),
    .cls (cls_hi)
  );

  // Low half first; high half continues from its result.
  always_comb begin
    lo       = step(st, len, cls_lo);
    hi       = step(lo.st, lo.len, cls_hi);
    n_err    = {1'b0, |lo.err} + {1'b0, |hi.err};
    err_sum  = {1'b0, err_cnt} + {15'd0, n_err};
    done     = lo.done | hi.done;
    done_len = hi.done ? hi.done_len : lo.done_len;
  end

  always_ff @(posedge clk120) begin
    if (rst) begin
      data_out  <= '0;
      k_out     <= '0;
      st        <= IDLE_ST;
      len       <= '0;
      in_frame  <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      last_len  <= '0;
      err_flags <= '0;
      err_pulse <= 1'b0;
    end else begin
      data_out  <= data_in;
      k_out     <= k_in;
      st        <= hi.st;
      len       <= hi.len;
      in_frame  <= (hi.st == FRAME_ST);
      err_pulse <= |(lo.err | hi.err);
      if (clr_cnt) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
        last_len  <= '0;
        err_flags <= '0;
      end else begin
        if (done) begin
          frame_cnt <= frame_cnt + 32'd1;
          last_len  <= done_len;
        end
        err_cnt   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        err_flags <= err_flags | lo.err | hi.err;
      end
    end
  end

endmodule

// File: doc/felix_tx_link_monitor.md
# felix_tx_link_monitor

Passive checker on the 64-bit/8-bit K stream that feeds the FELIX PCS at 120 MHz. It splits each input word into two 32-bit half-words and decodes each one against the FELIX full-mode framing rules (idle comma, SOP, EOP, data). It tracks frame state, counts good frames and protocol errors, and measures frame length. The stream is passed through with a fixed one-cycle delay, so the block can be inserted between the TX channel controller and the PCS without changing link behaviour.

## Interface
Parameters:
- `K_IDLE`, 8'hBC: K28.5 idle comma.
- `K_SOP`, 8'h3C: K28.1 start of frame.
- `K_EOP`, 8'hDC: K28.6 end of frame.

Ports:
- `clk120`  in  1  link clock; all logic is in this domain.
- `rst`  in  1  reset: synchronous, active-high; clock clk120.
- `data_in`  in  64  TX data word; the half in [31:0] comes first in time, then [63:32].
- `k_in`  in  8  K flags; [3:0] go with data_in[31:0], [7:4] with data_in[63:32].
- `clr_cnt`  in  1  synchronous clear of counters, last_len and sticky flags.
- `data_out`  out  64  data_in delayed by one cycle.
- `k_out`  out  8  k_in delayed by one cycle.
- `in_frame`  out  1  set while an SOP has been accepted and no EOP has been seen yet.
- `frame_cnt`  out  32  number of good frames; wraps modulo 2^32.
- `err_cnt`  out  16  number of errors; saturates at 16'hFFFF.
- `last_len`  out  16  data half-words in the last good frame; saturates at 16'hFFFF.
- `err_flags`  out  4  sticky error flags: [0] SOP inside a frame, [1] EOP while idle, [2] data while idle, [3] illegal K pattern.
- `err_pulse`  out  1  high for one cycle after any cycle that contained an error.

## Operation
Each half-word is classified as follows:
- **IDLE**: k=4'b0001 and byte0=K_IDLE.
- **SOP**: k=4'b0001 and byte0=K_SOP.
- **EOP**: k=4'b0001 and byte0=K_EOP.
- **DATA**: k=4'b0000.
- **BADK**: anything else.

State machine per half-word, states IDLE_ST and FRAME_ST. Low half is evaluated first; high half sees the state the low half leaves behind.

In IDLE_ST:
- SOP: go to FRAME_ST, clear the length counter.
- IDLE: stay.
- EOP: raise err[1], stay.
- DATA: raise err[2], stay.
- BADK: raise err[3], stay.

In FRAME_ST:
- DATA: length +1, saturating at 16'hFFFF.
- IDLE: allowed (fill), length unchanged.
- EOP: frame_cnt +1, last_len ← length, go to IDLE_ST.
- SOP: raise err[0], drop the current frame (not counted), clear length, stay in FRAME_ST.
- BADK: raise err[3], abort the frame, go to IDLE_ST.

Counting rules:
- err_cnt adds 0, 1 or 2 per cycle (two erroring halves add 2), saturating at 16'hFFFF.
- err_flags bits are set by the matching error and hold until clr_cnt or rst.
- EOP in the low half and SOP in the high half of the same cycle: the frame is counted and a new frame starts; no error.
- An SOP+EOP pair inside one word counts a frame with last_len=0.

Clear and reset behaviour:
- clr_cnt clears frame_cnt, err_cnt, last_len and err_flags; frame state and the length counter are kept.
- If clr_cnt and an event occur in the same cycle, the clear wins and the event's count update is lost. err_pulse still fires for errors in that cycle.
- rst drives every output to 0 and puts the state machine in IDLE_ST. rst takes priority over clr_cnt. A frame in progress at reset is discarded and not counted.

## Timing
- data_out/k_out: exactly one cycle of latency, always, including during errors.
- Status outputs (in_frame, frame_cnt, err_cnt, last_len, err_flags, err_pulse) are registered and reflect input cycle N at cycle N+1. This keeps them aligned with data_out.
- There is no back-pressure; the block accepts a word every cycle.
- Reset value of every output is 0.

## Structure
- Package `felix_link_pkg`:
  - K constants (K_IDLE, K_SOP, K_EOP).
  - enum `half_t` {H_IDLE, H_SOP, H_EOP, H_DATA, H_BADK}.
  - Error bit indices ERR_SOP_IN_FRAME=0, ERR_EOP_IDLE=1, ERR_DATA_IDLE=2, ERR_BADK=3.
- Sub-module `felix_half_classify`: combinational, 32-bit data + 4-bit K in, half_t out. It is instantiated twice, once per half.
- The top level chains two next-state/length evaluations per cycle, then does the registered counter update.

## Test plan
- Reset, then idle words 64'h000000BC_000000BC with k=8'h11 for 10 cycles → all outputs 0, in_frame=0, data_out equals data_in one cycle later.
- SOP (low), then 6 data half-words across 3 cycles, then EOP (high) → frame_cnt=1, last_len=6, err_cnt=0, in_frame drops the cycle after EOP.
- DATA half-word while idle, then EOP while idle in one word → err_cnt=2, err_flags=4'b0110, err_pulse high for one cycle.
- SOP, 3 data, SOP, 2 data, EOP → frame_cnt=1, last_len=2, err_flags[0]=1, err_cnt=1.
- In a frame, k=4'b0011 → err_flags[3]=1, in_frame=0. A following EOP raises err[1] and takes err_cnt to 2.
- Force err_cnt to 16'hFFFE with repeated errors, then send a word with two errors → err_cnt=16'hFFFF. Assert clr_cnt during a frame → counters 0, in_frame stays 1, and the next EOP gives frame_cnt=1.
